// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch and its display scan.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // All anodes released (active-low)
    localparam logic [3:0] AN_OFF = 4'b1111;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low seven-segment pattern.
module seg7_decode
    import stopwatch_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Map each BCD code to its pattern; non-BCD codes blank the digit
    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/stopwatch_bcd_scan.sv
// MM:SS stopwatch counting rising edges of the divider level, with a
// 4-digit multiplexed active-low seven-segment display driver.
module stopwatch_bcd_scan
    import stopwatch_pkg::*;
#(
    parameter int SCAN_DIV = 16
) (
    input  logic       I_CLK,
    input  logic       Rst,
    input  logic       I_TICK,
    input  logic       I_START_STOP,
    input  logic       I_CLEAR,
    output logic [3:0] O_AN,
    output logic [6:0] O_SEG,
    output logic       O_DP,
    output logic       O_RUN,
    output logic       O_WRAP
);

    localparam int SCW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_DIV - 1);

    sw_state_t      state;
    sw_state_t      state_nxt;
    logic           tick_d;
    logic           tick_edge;
    logic           inc;
    logic           all_max;
    logic [3:0]     sec_lo;
    logic [3:0]     sec_hi;
    logic [3:0]     min_lo;
    logic [3:0]     min_hi;
    logic [SCW-1:0] scan_cnt;
    logic [1:0]     scan_idx;
    logic [3:0]     cur_digit;
    logic [6:0]     seg_dec;

    // tick_d resets high so a level already high at release is not an edge
    assign tick_edge = I_TICK & ~tick_d;
    assign all_max   = (sec_lo == 4'd9) && (sec_hi == 4'd5) &&
                       (min_lo == 4'd9) && (min_hi == 4'd5);

    // Previous tick level for rising-edge detection
    always_ff @(posedge I_CLK or posedge Rst) begin
        if (Rst) tick_d <= 1'b1;
        else     tick_d <= I_TICK;
    end

    // FSM state register
    always_ff @(posedge I_CLK or posedge Rst) begin
        if (Rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and increment enable; clear overrides everything
    always_comb begin
        state_nxt = state;
        inc       = 1'b0;
        if (I_CLEAR) begin
            state_nxt = IDLE;
        end else begin
            inc = (state == RUN) && tick_edge;
            if (I_START_STOP) begin
                case (state)
                    IDLE:    state_nxt = RUN;
                    RUN:     state_nxt = PAUSE;
                    PAUSE:   state_nxt = RUN;
                    default: state_nxt = IDLE;
                endcase
            end
        end
    end

    // BCD digit chain with single-cycle ripple carry, 59:59 rolls to 00:00
    always_ff @(posedge I_CLK or posedge Rst) begin
        if (Rst || I_CLEAR) begin
            sec_lo <= 4'd0;
            sec_hi <= 4'd0;
            min_lo <= 4'd0;
            min_hi <= 4'd0;
        end else if (inc) begin
            if (sec_lo == 4'd9) begin
                sec_lo <= 4'd0;
                if (sec_hi == 4'd5) begin
                    sec_hi <= 4'd0;
                    if (min_lo == 4'd9) begin
                        min_lo <= 4'd0;
                        min_hi <= (min_hi == 4'd5) ? 4'd0 : min_hi + 4'd1;
                    end else begin
                        min_lo <= min_lo + 4'd1;
                    end
                end else begin
                    sec_hi <= sec_hi + 4'd1;
                end
            end else begin
                sec_lo <= sec_lo + 4'd1;
            end
        end
    end

    // Registered status: run flag follows state, wrap pulses on rollover
    always_ff @(posedge I_CLK or posedge Rst) begin
        if (Rst) begin
            O_RUN  <= 1'b0;
            O_WRAP <= 1'b0;
        end else begin
            O_RUN  <= (state == RUN);
            O_WRAP <= inc && all_max;
        end
    end

    // Digit scan: hold each digit SCAN_DIV cycles, runs in every state
    always_ff @(posedge I_CLK or posedge Rst) begin
        if (Rst) begin
            scan_cnt <= '0;
            scan_idx <= 2'd0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            scan_idx <= scan_idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Select the digit under the current scan index
    always_comb begin
        cur_digit = sec_lo;
        case (scan_idx)
            2'd0:    cur_digit = sec_lo;
            2'd1:    cur_digit = sec_hi;
            2'd2:    cur_digit = min_lo;
            default: cur_digit = min_hi;
        endcase
    end

    seg7_decode u_seg7_decode (
        .bcd (cur_digit),
        .seg (seg_dec)
    );

    // Anode, segments and DP registered together so they always agree
    always_ff @(posedge I_CLK or posedge Rst) begin
        if (Rst) begin
            O_AN  <= AN_OFF;
            O_SEG <= SEG_BLANK;
            O_DP  <= 1'b1;
        end else begin
            O_AN  <= ~(4'b0001 << scan_idx);
            O_SEG <= seg_dec;
            O_DP  <= (scan_idx != 2'd2);
        end
    end

endmodule

// File: tb/tb_stopwatch_bcd_scan.sv
// Self-checking bench for stopwatch_bcd_scan: reference count model,
// display scoreboard, scan-order checks on a second fast-scan instance.
module tb_stopwatch_bcd_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       ss;
    logic       clr;
    logic [3:0] an, an2;
    logic [6:0] seg, seg2;
    logic       dp, dp2, run, run2, wrap, wrap2;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: seconds count 0..3599, state 0=IDLE 1=RUN 2=PAUSE
    int m_cnt   = 0;
    int m_state = 0;
    bit m_wrap  = 1'b0;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } disp_t;
    disp_t exp_q[$];

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

    always #5 clk = ~clk;

    stopwatch_bcd_scan #(.SCAN_DIV(4)) u_dut (
        .I_CLK        (clk),
        .Rst          (rst),
        .I_TICK       (tick),
        .I_START_STOP (ss),
        .I_CLEAR      (clr),
        .O_AN         (an),
        .O_SEG        (seg),
        .O_DP         (dp),
        .O_RUN        (run),
        .O_WRAP       (wrap)
    );

    stopwatch_bcd_scan #(.SCAN_DIV(2)) u_dut2 (
        .I_CLK        (clk),
        .Rst          (rst),
        .I_TICK       (tick),
        .I_START_STOP (ss),
        .I_CLEAR      (clr),
        .O_AN         (an2),
        .O_SEG        (seg2),
        .O_DP         (dp2),
        .O_RUN        (run2),
        .O_WRAP       (wrap2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int digit(input int i);
        int s;
        int m;
        s = m_cnt % 60;
        m = m_cnt / 60;
        case (i)
            0:       return s % 10;
            1:       return s / 10;
            2:       return m % 10;
            default: return m / 10;
        endcase
    endfunction

    function automatic logic [3:0] get_an(input int which);
        return (which != 0) ? an2 : an;
    endfunction

    function automatic logic [6:0] get_seg(input int which);
        return (which != 0) ? seg2 : seg;
    endfunction

    function automatic logic get_dp(input int which);
        return (which != 0) ? dp2 : dp;
    endfunction

    // Apply one cycle of control inputs to the model
    task automatic model_ev(input bit s, input bit c, input bit edge_in);
        m_wrap = 1'b0;
        if (c) begin
            m_state = 0;
            m_cnt   = 0;
        end else begin
            if (m_state == 1 && edge_in) begin
                if (m_cnt == 3599) begin
                    m_cnt  = 0;
                    m_wrap = 1'b1;
                end else begin
                    m_cnt++;
                end
            end
            if (s) m_state = (m_state == 1) ? 2 : 1;
        end
    endtask

    // One I_TICK rising edge (optionally with start/stop and clear on that cycle)
    task automatic tick_ev(input bit s, input bit c, input int hi, input int lo);
        tick = 1'b1;
        ss   = s;
        clr  = c;
        model_ev(s, c, 1'b1);
        @(negedge clk);
        ss  = 1'b0;
        clr = 1'b0;
        chk("wrap", {31'd0, wrap}, {31'd0, m_wrap});
        repeat (hi - 1) @(negedge clk);
        tick = 1'b0;
        repeat (lo) @(negedge clk);
        chk("wrap_low", {31'd0, wrap}, 32'd0);
    endtask

    task automatic pulse(input bit s, input bit c);
        ss  = s;
        clr = c;
        model_ev(s, c, 1'b0);
        @(negedge clk);
        ss  = 1'b0;
        clr = 1'b0;
    endtask

    // Push the four expected digit frames, then pop each as its anode appears
    task automatic check_disp(input string tag);
        disp_t      e;
        logic [3:0] a;
        int         w;
        for (int i = 0; i < 4; i++) begin
            a = ~(4'b0001 << i);
            exp_q.push_back('{an: a, seg: seg_tab[digit(i)], dp: (i != 2)});
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            w = 0;
            while (an !== e.an && w < 64) begin
                @(negedge clk);
                w++;
            end
            if (w >= 64) begin
                chk({tag, "_an_timeout"}, {28'd0, an}, {28'd0, e.an});
            end else begin
                chk({tag, "_seg"}, {25'd0, seg}, {25'd0, e.seg});
                chk({tag, "_dp"}, {31'd0, dp}, {31'd0, e.dp});
            end
        end
    endtask

    // Two full scan rotations: anode order, per-digit hold length, DP, segments
    task automatic scan_chk(input string tag, input int which, input int div);
        int         w;
        logic [3:0] a;
        w = 0;
        while (get_an(which) !== 4'b0111 && w < 64) begin @(negedge clk); w++; end
        while (get_an(which) !== 4'b1110 && w < 128) begin @(negedge clk); w++; end
        if (w >= 128) begin
            chk({tag, "_sync_timeout"}, {28'd0, get_an(which)}, 32'he);
        end else begin
            for (int k = 0; k < 8 * div; k++) begin
                a = ~(4'b0001 << ((k / div) % 4));
                chk({tag, "_an"}, {28'd0, get_an(which)}, {28'd0, a});
                chk({tag, "_dp"}, {31'd0, get_dp(which)}, {31'd0, (((k / div) % 4) != 2)});
                chk({tag, "_seg"}, {25'd0, get_seg(which)}, {25'd0, seg_tab[digit((k / div) % 4)]});
                @(negedge clk);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_an"}, {28'd0, an}, 32'hf);
        chk({tag, "_seg"}, {25'd0, seg}, 32'h7f);
        chk({tag, "_dp"}, {31'd0, dp}, 32'd1);
        chk({tag, "_run"}, {31'd0, run}, 32'd0);
        chk({tag, "_wrap"}, {31'd0, wrap}, 32'd0);
    endtask

    initial begin
        rst  = 1'b1;
        tick = 1'b0;
        ss   = 1'b0;
        clr  = 1'b0;
        #12;
        check_reset_outputs("rst0");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("first_an", {28'd0, an}, 32'he);
        chk("first_seg", {25'd0, seg}, 32'h40);
        chk("first_run", {31'd0, run}, 32'd0);

        // Start and count 12 slow ticks
        pulse(1'b1, 1'b0);
        for (int i = 0; i < 12; i++) tick_ev(1'b0, 1'b0, 21, 21);
        chk("run_on", {31'd0, run}, 32'd1);
        chk("run2_on", {31'd0, run2}, 32'd1);
        check_disp("c0012");
        scan_chk("scan4", 0, 4);
        scan_chk("scan2", 1, 2);

        // Stop on the same cycle as an edge: counts once, then holds
        tick_ev(1'b1, 1'b0, 21, 21);
        for (int i = 0; i < 5; i++) tick_ev(1'b0, 1'b0, 21, 21);
        chk("run_paused", {31'd0, run}, 32'd0);
        check_disp("c0013");
        pulse(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick_ev(1'b0, 1'b0, 21, 21);
        chk("run_resumed", {31'd0, run}, 32'd1);
        check_disp("c0016");

        // Fast ticks to 59:59, then roll over
        while (m_cnt != 3599) tick_ev(1'b0, 1'b0, 1, 1);
        check_disp("c5959");
        tick_ev(1'b0, 1'b0, 1, 1);
        chk("wrap_model", {31'd0, m_wrap}, 32'd1);
        chk("run_after_wrap", {31'd0, run}, 32'd1);
        check_disp("c0000");

        // Clear beats start/stop and tick on the same cycle
        while (m_cnt != 207) tick_ev(1'b0, 1'b0, 1, 1);
        check_disp("c0327");
        tick_ev(1'b1, 1'b1, 1, 1);
        repeat (2) @(negedge clk);
        chk("run_cleared", {31'd0, run}, 32'd0);
        check_disp("clr");

        // Count again, then reset asynchronously mid-operation
        pulse(1'b1, 1'b0);
        for (int i = 0; i < 48; i++) tick_ev(1'b0, 1'b0, 1, 1);
        check_disp("c0048");
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        @(negedge clk);
        rst     = 1'b0;
        m_cnt   = 0;
        m_state = 0;
        @(negedge clk);
        chk("rel_an", {28'd0, an}, 32'he);
        chk("rel_seg", {25'd0, seg}, 32'h40);
        tick_ev(1'b0, 1'b0, 2, 2);
        chk("rel_run", {31'd0, run}, 32'd0);
        check_disp("after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
